// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared types and constants for the serial link power sequencer.
package serial_link_pkg;

    typedef enum logic [2:0] {
        PWR_OFF,
        PWR_CLK_ON,
        PWR_DEISO,
        PWR_UP,
        PWR_ISO,
        PWR_RST_ON
    } pwr_seq_state_e;

    localparam logic [1:0] PwrSeqIsoAll  = 2'b11;
    localparam logic [1:0] PwrSeqIsoNone = 2'b00;

endpackage

// File: rtl/serial_link_pwr_seq_timer.sv
// serial_link_pwr_seq_timer: loadable down-counter that saturates at zero.
module serial_link_pwr_seq_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else if (load_i) cnt_q <= load_val_i;
        else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end

    assign expired_o = cnt_q == '0;

endmodule

// File: rtl/serial_link_pwr_seq.sv
// serial_link_pwr_seq: ordered clock/reset/isolation bring-up and teardown for the link domain.
// Define SERIAL_LINK_PWR_SEQ_TIMEOUT_EN to bound the isolation handshakes with TimeoutCycles.
module serial_link_pwr_seq
    import serial_link_pkg::*;
#(
    parameter int unsigned RstHoldCycles = 8,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_on_i,
    input  logic [1:0] isolated_i,
    input  logic       clr_err_i,
    output logic       clk_ena_o,
    output logic       reset_no,
    output logic [1:0] isolate_o,
    output logic       up_o,
    output logic       busy_o,
    output logic       timeout_o
);

`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
    localparam int unsigned CntMax = RstHoldCycles > TimeoutCycles ? RstHoldCycles : TimeoutCycles;
    localparam logic        ToEn   = 1'b1;
`else
    localparam int unsigned CntMax = RstHoldCycles;
    localparam logic        ToEn   = 1'b0;
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TimeoutCycles;
`endif
    localparam int unsigned   CntW     = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] TimeLoad = ToEn ? CntW'(CntMax - 1) : HoldLoad;

    pwr_seq_state_e  state_q, state_d;
    logic            expired, to_hit, timeout_q;
    logic [CntW-1:0] load_val;

    always_comb begin
        state_d = state_q;
        to_hit  = 1'b0;
        case (state_q)
            PWR_OFF:    if (req_on_i) state_d = PWR_CLK_ON;
            PWR_CLK_ON: state_d = !req_on_i ? PWR_ISO : expired ? PWR_DEISO : PWR_CLK_ON;
            PWR_DEISO: begin
                // A handshake match in the expiry cycle still counts as success.
                if (!req_on_i) state_d = PWR_ISO;
                else if (isolated_i == PwrSeqIsoNone) state_d = PWR_UP;
                else if (ToEn && expired) begin
                    state_d = PWR_ISO;
                    to_hit  = 1'b1;
                end
            end
            PWR_UP:     if (!req_on_i) state_d = PWR_ISO;
            PWR_ISO: begin
                if (isolated_i == PwrSeqIsoAll) state_d = PWR_RST_ON;
                else if (ToEn && expired) begin
                    state_d = PWR_RST_ON;
                    to_hit  = 1'b1;
                end
            end
            PWR_RST_ON: if (expired) state_d = PWR_OFF;
            default:    state_d = PWR_OFF;
        endcase
    end

    assign load_val = (state_d == PWR_CLK_ON || state_d == PWR_RST_ON) ? HoldLoad : TimeLoad;

    serial_link_pwr_seq_timer #(.Width(CntW)) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_d != state_q),
        .load_val_i (load_val),
        .expired_o  (expired)
    );

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= PWR_OFF;
            clk_ena_o <= 1'b0;
            reset_no  <= 1'b0;
            isolate_o <= PwrSeqIsoAll;
            up_o      <= 1'b0;
            busy_o    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_ena_o <= state_d != PWR_OFF;
            reset_no  <= state_d inside {PWR_DEISO, PWR_UP, PWR_ISO};
            isolate_o <= state_d inside {PWR_DEISO, PWR_UP} ? PwrSeqIsoNone : PwrSeqIsoAll;
            up_o      <= state_d == PWR_UP;
            busy_o    <= !(state_d inside {PWR_OFF, PWR_UP});
            timeout_q <= to_hit | (timeout_q & ~(clr_err_i & ToEn));
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_serial_link_pwr_seq.sv
// tb_serial_link_pwr_seq: directed bench for the power sequencer, RstHoldCycles=8, TimeoutCycles=16.
module tb_serial_link_pwr_seq;

    localparam logic [5:0] O_OFF   = 6'b0011_00;
    localparam logic [5:0] O_CLK   = 6'b1011_01;
    localparam logic [5:0] O_DEISO = 6'b1100_01;
    localparam logic [5:0] O_UP    = 6'b1100_10;
    localparam logic [5:0] O_ISO   = 6'b1111_01;
    localparam logic [5:0] O_RST   = 6'b1011_01;

    logic       clk = 1'b0;
    logic       rst_n, req_on, clr_err;
    logic [1:0] isolated;
    logic       clk_ena, reset_n, up, busy, timeout;
    logic [1:0] isolate;
    logic [5:0] outs;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign outs = {clk_ena, reset_n, isolate, up, busy};

    serial_link_pwr_seq #(.RstHoldCycles(8), .TimeoutCycles(16)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_on_i   (req_on),
        .isolated_i (isolated),
        .clr_err_i  (clr_err),
        .clk_ena_o  (clk_ena),
        .reset_no   (reset_n),
        .isolate_o  (isolate),
        .up_o       (up),
        .busy_o     (busy),
        .timeout_o  (timeout)
    );

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_on = 1'b0; isolated = 2'b11; clr_err = 1'b0;
        cyc(2);
        check("rst_outs", outs, O_OFF);
        check("rst_timeout", 6'(timeout), 6'd0);
        rst_n = 1'b1;
        cyc(1);
        check("off_idle", outs, O_OFF);

        // bring-up
        req_on = 1'b1;
        cyc(1); check("up_c1_clk_on", outs, O_CLK);
        cyc(7); check("up_c8_clk_on", outs, O_CLK);
        cyc(1); check("up_c9_deiso", outs, O_DEISO);
        cyc(2); isolated = 2'b00; check("up_c11_deiso", outs, O_DEISO);
        cyc(1); check("up_c12_up", outs, O_UP);

        // teardown from UP
        req_on = 1'b0;
        cyc(1); check("td_iso", outs, O_ISO);
        cyc(3); isolated = 2'b11; check("td_iso_wait", outs, O_ISO);
        for (int i = 0; i < 8; i++) begin
            cyc(1); check("td_rst_on", outs, O_RST);
        end
        cyc(1); check("td_off", outs, O_OFF);

        // abort in CLK_ON, then re-request during RST_ON
        req_on = 1'b1;
        cyc(1); check("ab_c1_clk_on", outs, O_CLK);
        cyc(2); req_on = 1'b0; check("ab_c3_clk_on", outs, O_CLK);
        cyc(1); check("ab_c4_iso", outs, O_ISO);
        cyc(1); check("ab_c5_rst_on", outs, O_RST);
        cyc(3); req_on = 1'b1; check("ab_c8_rst_on", outs, O_RST);
        cyc(4); check("ab_c12_rst_on", outs, O_RST);
        cyc(1); check("rr_c13_off", outs, O_OFF);
        cyc(1); isolated = 2'b00; check("rr_c14_clk_on", outs, O_CLK);
        cyc(8); check("rr_c22_deiso", outs, O_DEISO);
        cyc(1); check("rr_c23_up", outs, O_UP);

        // isolation handshake stuck at 01 in ISO
        req_on = 1'b0; isolated = 2'b01;
        cyc(1); check("to_t1_iso", outs, O_ISO);
        cyc(15); check("to_t16_iso", outs, O_ISO);
        check("to_t16_flag", 6'(timeout), 6'd0);
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        cyc(1); check("to_t17_rst_on", outs, O_RST);
        check("to_t17_flag", 6'(timeout), 6'd1);
        clr_err = 1'b1;
        cyc(1); clr_err = 1'b0;
        check("to_clr_flag", 6'(timeout), 6'd0);
        check("to_t18_rst_on", outs, O_RST);
        cyc(7); check("to_t25_off", outs, O_OFF);
        isolated = 2'b11;
`else
        cyc(1); check("to_t17_iso", outs, O_ISO);
        check("to_t17_flag", 6'(timeout), 6'd0);
        cyc(10); check("to_t27_iso", outs, O_ISO);
        clr_err = 1'b1;
        cyc(1); clr_err = 1'b0; isolated = 2'b11;
        check("to_flag_tied", 6'(timeout), 6'd0);
        cyc(1); check("to_rst_on", outs, O_RST);
        cyc(8); check("to_off", outs, O_OFF);
`endif

        // async reset while UP
        isolated = 2'b00; req_on = 1'b1;
        cyc(1); check("ar_clk_on", outs, O_CLK);
        cyc(8); check("ar_deiso", outs, O_DEISO);
        cyc(1); check("ar_up", outs, O_UP);
        #2 rst_n = 1'b0;
        #1 check("ar_async_off", outs, O_OFF);
        check("ar_async_flag", 6'(timeout), 6'd0);
        cyc(1);
        rst_n = 1'b1; req_on = 1'b0; isolated = 2'b11;
        cyc(1); check("ar_released_off", outs, O_OFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
